// File: rtl/axi4_stream_pkt_gen.sv
// AXI4-Stream packet generator: emits cfg_num packets of cfg_len incrementing samples,
// DN lanes per beat, starting from cfg_sed and continuing across packet boundaries.
module axi4_stream_pkt_gen #(
    parameter int DN = 4,
    parameter int DW = 16,
    parameter int CW = 32
) (
    input  logic               ACLK,
    input  logic               ARESET,
    input  logic               ctl_str,
    input  logic               ctl_stp,
    input  logic [CW-1:0]      cfg_len,
    input  logic [CW-1:0]      cfg_num,
    input  logic [DW-1:0]      cfg_sed,
    output logic               sts_run,
    output logic [CW-1:0]      sts_pkt,
    output logic [CW-1:0]      sts_cur,
    output logic [DN*DW-1:0]   TDATA,
    output logic [DN-1:0]      TKEEP,
    output logic               TLAST,
    output logic               TVALID,
    input  logic               TREADY
);

    typedef enum logic {IDLE, RUN} state_t;

    localparam logic [CW-1:0] DN_W = CW'(DN);

    state_t        state, state_nxt;
    logic [CW-1:0] len_r, num_r, rem, k, pkt_inc;
    logic [DW-1:0] smp;
    logic          stop_pend;
    logic          run, last, xfer, start, finish;

    assign run     = (state == RUN);
    assign last    = (rem <= DN_W);
    assign k       = last ? rem : DN_W;
    assign xfer    = run & TREADY;
    assign pkt_inc = sts_pkt + 1'b1;
    // Stop beats start when both arrive in IDLE.
    assign start   = ctl_str & ~ctl_stp & (cfg_len != '0);
    assign finish  = xfer & last &
                     (((num_r != '0) & (pkt_inc == num_r)) | stop_pend | ctl_stp);

    always_ff @(posedge ACLK) begin
        if (ARESET) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        // NOTE: every combinational output gets a default first so no path infers a latch.
        state_nxt = state;
        case (state)
            IDLE:    if (start)  state_nxt = RUN;
            RUN:     if (finish) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // rem counts samples still owed in the current packet; it reloads from len_r on TLAST.
    always_ff @(posedge ACLK) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update together.
        if (ARESET) begin
            len_r     <= '0;
            num_r     <= '0;
            rem       <= '0;
            smp       <= '0;
            sts_pkt   <= '0;
            sts_cur   <= '0;
            stop_pend <= 1'b0;
        end else if (!run) begin
            stop_pend <= 1'b0;
            if (start) begin
                len_r   <= cfg_len;
                num_r   <= cfg_num;
                smp     <= cfg_sed;
                rem     <= cfg_len;
                sts_pkt <= '0;
                sts_cur <= '0;
            end
        end else begin
            if (ctl_stp) stop_pend <= 1'b1;
            if (xfer) begin
                smp <= smp + DW'(k);
                if (last) begin
                    rem     <= len_r;
                    sts_cur <= '0;
                    sts_pkt <= pkt_inc;
                    if (finish) stop_pend <= 1'b0;
                end else begin
                    rem     <= rem - DN_W;
                    sts_cur <= sts_cur + DN_W;
                end
            end
        end
    end

    // Beat contents derive purely from registered state, so they hold while TREADY is low.
    always_comb begin
        TDATA = '0;
        TKEEP = '0;
        for (int i = 0; i < DN; i++) begin
            if (run && (CW'(i) < k)) begin
                TKEEP[i]          = 1'b1;
                TDATA[i*DW +: DW] = smp + DW'(i);
            end
        end
    end

    assign TVALID  = run;
    assign TLAST   = run & last;
    assign sts_run = run;

endmodule
